// File: rtl/core_mdu_pkg.sv
// ============================================================================
// core_mdu_pkg : shared MDU op encoding and sequencer state types. Rev 1.0
// ============================================================================
`default_nettype none

package core_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  function automatic logic [7:0] mdu_op_onehot(input mdu_op_t op);
    return 8'b1 << op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_mdu_result_cache.sv
// ============================================================================
// core_mdu_result_cache : one-entry {op,word,rs1,rs2} -> result cache. Rev 1.0
// ============================================================================
`default_nettype none

module core_mdu_result_cache
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            g_clk_i,
  input  logic            g_resetn_i,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_op_i,
  input  logic            wr_word_i,
  input  logic [XLEN-1:0] wr_rs1_i,
  input  logic [XLEN-1:0] wr_rs2_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [2:0]      lk_op_i,
  input  logic            lk_word_i,
  input  logic [XLEN-1:0] lk_rs1_i,
  input  logic [XLEN-1:0] lk_rs2_i,
  output logic            hit_o,
  output logic [XLEN-1:0] hit_data_o
);

  localparam int TAG_W = 2*XLEN + 4;

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  data_q;

  always_ff @(posedge g_clk_i or negedge g_resetn_i) begin
    if (!g_resetn_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= {wr_op_i, wr_word_i, wr_rs1_i, wr_rs2_i};
      data_q  <= wr_data_i;
    end
  end

  assign hit_o      = valid_q && (tag_q == {lk_op_i, lk_word_i, lk_rs1_i, lk_rs2_i});
  assign hit_data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/core_pipe_exec_mdu_ctrl.sv
// ============================================================================
// core_pipe_exec_mdu_ctrl : decode->MDU sequencer with writeback handshake. Rev 1.0
// ============================================================================
`default_nettype none

module core_pipe_exec_mdu_ctrl
  import core_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2:0]      s_op,
  input  logic            s_word,
  input  logic [XLEN-1:0] s_rs1,
  input  logic [XLEN-1:0] s_rs2,
  input  logic [4:0]      s_rd_addr,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4:0]      m_rd_addr,
  output logic [XLEN-1:0] m_rd_data,
  output logic            mdu_valid,
  output logic            mdu_flush,
  output logic            mdu_word,
  output logic            mdu_op_mul,
  output logic            mdu_op_mulh,
  output logic            mdu_op_mulhu,
  output logic            mdu_op_mulhsu,
  output logic            mdu_op_div,
  output logic            mdu_op_divu,
  output logic            mdu_op_rem,
  output logic            mdu_op_remu,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  input  logic            mdu_ready,
  input  logic [XLEN-1:0] mdu_rd
);

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q;
  logic            word_q;
  logic [XLEN-1:0] rs1_q, rs2_q, result_q;
  logic [4:0]      rd_q;

  logic            accept;
  logic            run_done;
  logic            cache_hit;
  logic [XLEN-1:0] cache_data;
  logic [7:0]      op_lines;

  assign accept   = s_valid && s_ready;
  // A flush racing the MDU completion discards the result, so it is not cached.
  assign run_done = (state_q == ST_RUN) && mdu_ready && !flush;

  generate
    if (CACHE_EN) begin : g_cache
      core_mdu_result_cache #(
        .XLEN (XLEN)
      ) u_cache (
        .g_clk_i    (g_clk),
        .g_resetn_i (g_resetn),
        .wr_en_i    (run_done),
        .wr_op_i    (op_q),
        .wr_word_i  (word_q),
        .wr_rs1_i   (rs1_q),
        .wr_rs2_i   (rs2_q),
        .wr_data_i  (mdu_rd),
        .lk_op_i    (s_op),
        .lk_word_i  (s_word),
        .lk_rs1_i   (s_rs1),
        .lk_rs2_i   (s_rs2),
        .hit_o      (cache_hit),
        .hit_data_o (cache_data)
      );
    end else begin : g_nocache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = cache_hit ? ST_DONE : ST_RUN;
      ST_RUN:  if (mdu_ready) state_d = ST_DONE;
      ST_DONE: if (m_ready) state_d = accept ? (cache_hit ? ST_DONE : ST_RUN) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      op_q     <= MDU_MUL;
      word_q   <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= mdu_op_t'(s_op);
        word_q <= s_word;
        rs1_q  <= s_rs1;
        rs2_q  <= s_rs2;
        rd_q   <= s_rd_addr;
        if (cache_hit) result_q <= cache_data;
      end else if (run_done) begin
        result_q <= mdu_rd;
      end
    end
  end

  always_comb begin
    s_ready   = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && m_ready));
    m_valid   = (state_q == ST_DONE);
    mdu_valid = (state_q == ST_RUN);
    mdu_flush = flush || ((state_q == ST_RUN) && mdu_ready);
    op_lines  = mdu_valid ? mdu_op_onehot(op_q) : 8'b0;
  end

  assign mdu_op_mul    = op_lines[MDU_MUL];
  assign mdu_op_mulh   = op_lines[MDU_MULH];
  assign mdu_op_mulhsu = op_lines[MDU_MULHSU];
  assign mdu_op_mulhu  = op_lines[MDU_MULHU];
  assign mdu_op_div    = op_lines[MDU_DIV];
  assign mdu_op_divu   = op_lines[MDU_DIVU];
  assign mdu_op_rem    = op_lines[MDU_REM];
  assign mdu_op_remu   = op_lines[MDU_REMU];

  assign mdu_word  = word_q;
  assign mdu_rs1   = rs1_q;
  assign mdu_rs2   = rs2_q;
  assign m_rd_addr = rd_q;
  assign m_rd_data = result_q;

endmodule

`default_nettype wire

// File: tb/tb_core_pipe_exec_mdu_ctrl.sv
// ============================================================================
// tb_core_pipe_exec_mdu_ctrl : directed bench; the bench plays the MDU. Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_pipe_exec_mdu_ctrl;

  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            flush = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [2:0]      s_op = 3'd0;
  logic            s_word = 1'b0;
  logic [XLEN-1:0] s_rs1 = '0;
  logic [XLEN-1:0] s_rs2 = '0;
  logic [4:0]      s_rd_addr = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [4:0]      m_rd_addr;
  logic [XLEN-1:0] m_rd_data;
  logic            mdu_valid, mdu_flush, mdu_word;
  logic            mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu;
  logic            mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu;
  logic [XLEN-1:0] mdu_rs1, mdu_rs2;
  logic            mdu_ready = 1'b0;
  logic [XLEN-1:0] mdu_rd = '0;

  int checks = 0;
  int errors = 0;
  int flush_cnt = 0;
  int base;

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) if (mdu_flush) flush_cnt++;

  core_pipe_exec_mdu_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_word(s_word),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd_addr(s_rd_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data),
    .mdu_valid(mdu_valid), .mdu_flush(mdu_flush), .mdu_word(mdu_word),
    .mdu_op_mul(mdu_op_mul), .mdu_op_mulh(mdu_op_mulh), .mdu_op_mulhu(mdu_op_mulhu),
    .mdu_op_mulhsu(mdu_op_mulhsu), .mdu_op_div(mdu_op_div), .mdu_op_divu(mdu_op_divu),
    .mdu_op_rem(mdu_op_rem), .mdu_op_remu(mdu_op_remu),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op, hold until accepted; returns mid-cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    int n;
    s_valid = 1'b1; s_op = op; s_word = w; s_rs1 = a; s_rs2 = b; s_rd_addr = rd;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge g_clk); #1; n++;
    end
    chk("accept_timeout", {63'd0, s_ready}, 64'd1);
    @(negedge g_clk);
    s_valid = 1'b0;
    #1;
  endtask

  task automatic run_mdu(input int lat, input logic [63:0] res);
    repeat (lat) @(negedge g_clk);
    mdu_ready = 1'b1; mdu_rd = res;
    #1;
    chk("mdu_flush_on_ready", {63'd0, mdu_flush}, 64'd1);
    @(negedge g_clk);
    mdu_ready = 1'b0; mdu_rd = '0;
    #1;
  endtask

  task automatic drain(input string tag, input logic [63:0] data, input logic [4:0] rd);
    chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd1);
    chk({tag, "_data"}, m_rd_data, data);
    chk({tag, "_rd"}, {59'd0, m_rd_addr}, {59'd0, rd});
    m_ready = 1'b1;
    @(negedge g_clk);
    m_ready = 1'b0;
    #1;
    chk({tag, "_m_valid_drop"}, {63'd0, m_valid}, 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_data", m_rd_data, 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk); #1;

    // MUL 7*6: miss path, single flush pulse
    base = flush_cnt;
    issue(3'd0, 1'b0, 64'd7, 64'd6, 5'd1);
    chk("mul_mdu_valid", {63'd0, mdu_valid}, 64'd1);
    chk("mul_op_line", {63'd0, mdu_op_mul}, 64'd1);
    chk("mul_op_div_low", {63'd0, mdu_op_div}, 64'd0);
    chk("mul_rs1", mdu_rs1, 64'd7);
    chk("mul_rs2", mdu_rs2, 64'd6);
    chk("mul_m_valid_low", {63'd0, m_valid}, 64'd0);
    run_mdu(4, 64'd42);
    chk("mul_mdu_valid_off", {63'd0, mdu_valid}, 64'd0);
    drain("mul", 64'd42, 5'd1);
    chk("mul_flush_pulses", flush_cnt - base, 64'd1);

    // DIVU then REMU by zero: distinct tags
    issue(3'd5, 1'b0, 64'd100, 64'd0, 5'd2);
    chk("divu_miss", {63'd0, mdu_op_divu}, 64'd1);
    run_mdu(6, ONES);
    drain("divu", ONES, 5'd2);
    issue(3'd7, 1'b0, 64'd100, 64'd0, 5'd3);
    chk("remu_miss", {63'd0, mdu_valid}, 64'd1);
    chk("remu_op_line", {63'd0, mdu_op_remu}, 64'd1);
    run_mdu(6, 64'd100);
    drain("remu", 64'd100, 5'd3);

    // MULH twice: second issue hits
    issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd4);
    chk("mulh1_miss", {63'd0, mdu_op_mulh}, 64'd1);
    run_mdu(3, ONES);
    drain("mulh1", ONES, 5'd4);
    issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd5);
    chk("mulh2_hit_m_valid", {63'd0, m_valid}, 64'd1);
    chk("mulh2_hit_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    chk("mulh2_hit_data", m_rd_data, ONES);

    // Backpressure in DONE with a pending op
    s_valid = 1'b1; s_op = 3'd0; s_word = 1'b0; s_rs1 = 64'd3; s_rs2 = 64'd5; s_rd_addr = 5'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
      chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_data", m_rd_data, ONES);
      chk("bp_rd", {59'd0, m_rd_addr}, 64'd5);
      chk("bp_mdu_valid", {63'd0, mdu_valid}, 64'd0);
      @(negedge g_clk);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release_s_ready", {63'd0, s_ready}, 64'd1);
    @(negedge g_clk);
    m_ready = 1'b0; s_valid = 1'b0;
    #1;
    chk("b2b_run", {63'd0, mdu_valid}, 64'd1);
    chk("b2b_op", {63'd0, mdu_op_mul}, 64'd1);
    chk("b2b_m_valid_low", {63'd0, m_valid}, 64'd0);
    run_mdu(2, 64'd15);
    drain("b2b", 64'd15, 5'd9);

    // Flush at cycle 20 of a 64-bit DIV
    issue(3'd4, 1'b0, 64'd1000, 64'd3, 5'd10);
    repeat (19) @(negedge g_clk);
    #1;
    chk("div_still_run", {63'd0, mdu_op_div}, 64'd1);
    flush = 1'b1; s_valid = 1'b1; s_op = 3'd0; s_rs1 = 64'd1; s_rs2 = 64'd1;
    #1;
    chk("flush_mdu_flush", {63'd0, mdu_flush}, 64'd1);
    chk("flush_s_ready", {63'd0, s_ready}, 64'd0);
    @(negedge g_clk);
    flush = 1'b0; s_valid = 1'b0;
    #1;
    chk("flush_idle_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    chk("flush_no_m_valid", {63'd0, m_valid}, 64'd0);
    chk("flush_idle_s_ready", {63'd0, s_ready}, 64'd1);
    @(negedge g_clk); #1;
    chk("flush_no_m_valid2", {63'd0, m_valid}, 64'd0);
    issue(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11);
    chk("divw_word", {63'd0, mdu_word}, 64'd1);
    chk("divw_op", {63'd0, mdu_op_div}, 64'd1);
    run_mdu(33, 64'hFFFF_FFFF_FFFF_FFFD);
    drain("divw", 64'hFFFF_FFFF_FFFF_FFFD, 5'd11);

    // Async reset mid-RUN clears outputs and invalidates the cache
    issue(3'd0, 1'b0, 64'd11, 64'd13, 5'd12);
    run_mdu(3, 64'd143);
    drain("mul143", 64'd143, 5'd12);
    issue(3'd5, 1'b0, 64'd9, 64'd3, 5'd13);
    @(negedge g_clk); #1;
    chk("pre_rst_run", {63'd0, mdu_valid}, 64'd1);
    g_resetn = 1'b0;
    #1;
    chk("arst_mdu_valid", {63'd0, mdu_valid}, 64'd0);
    chk("arst_op_divu", {63'd0, mdu_op_divu}, 64'd0);
    chk("arst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("arst_rs1", mdu_rs1, 64'd0);
    chk("arst_data", m_rd_data, 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk); #1;
    issue(3'd0, 1'b0, 64'd11, 64'd13, 5'd14);
    chk("post_rst_miss", {63'd0, mdu_valid}, 64'd1);
    chk("post_rst_no_hit", {63'd0, m_valid}, 64'd0);
    run_mdu(3, 64'd143);
    drain("post_rst", 64'd143, 5'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
